// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a parallel pattern and shifts it out MSB-first,
// optionally repeating it with a forced-low gap between repetitions.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LW    = 4,
    parameter int unsigned RW    = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    input  logic [RW-1:0]    reps,
    output logic             ready,
    output logic             busy,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [LW-1:0] LenMax  = LW'(WIDTH);
    localparam int unsigned   GW      = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GapLoad = GW'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]    rep_cnt_q, rep_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             bit_out_q, bit_out_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [LW-1:0]    len_c;
    logic [WIDTH-1:0] cap_pat;

    // Pattern is left-aligned at capture so the next bit is always the MSB of the shifter.
    assign len_c   = (len > LenMax) ? LenMax : len;
    assign cap_pat = data << (LenMax - len_c);

    assign ready     = (state_q == StIdle);
    assign busy      = busy_q;
    assign bit_out   = bit_out_q;
    assign bit_valid = valid_q;
    assign done      = done_q;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sh_d      = sh_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        bit_out_d = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    pat_d     = cap_pat;
                    len_d     = len_c;
                    rep_cnt_d = (reps == '0) ? '0 : reps - RW'(1);
                    if (len_c == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = StShift;
                        bit_out_d = cap_pat[WIDTH-1];
                        valid_d   = 1'b1;
                        sh_d      = cap_pat << 1;
                        bit_cnt_d = len_c - LW'(1);
                        busy_d    = 1'b1;
                    end
                end
            end
            StShift: begin
                if (bit_cnt_q != '0) begin
                    bit_out_d = sh_q[WIDTH-1];
                    valid_d   = 1'b1;
                    sh_d      = sh_q << 1;
                    bit_cnt_d = bit_cnt_q - LW'(1);
                end else if (rep_cnt_q != '0) begin
                    if (GAP > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = GapLoad;
                    end else begin
                        bit_out_d = pat_q[WIDTH-1];
                        valid_d   = 1'b1;
                        sh_d      = pat_q << 1;
                        bit_cnt_d = len_q - LW'(1);
                        rep_cnt_d = rep_cnt_q - RW'(1);
                    end
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            StGap: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end else begin
                    state_d   = StShift;
                    bit_out_d = pat_q[WIDTH-1];
                    valid_d   = 1'b1;
                    sh_d      = pat_q << 1;
                    bit_cnt_d = len_q - LW'(1);
                    rep_cnt_d = rep_cnt_q - RW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            sh_q      <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            bit_out_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            sh_q      <= sh_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            bit_out_q <= bit_out_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: hand-computed bit streams and handshake timing.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] len = '0;
    logic [3:0] reps = '0;
    logic       ready, busy, bit_out, bit_valid, done;

    int total = 0;
    int passed = 0;

    serial_pattern_tx #(
        .WIDTH(8),
        .LW   (4),
        .RW   (4),
        .GAP  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data     (data),
        .len      (len),
        .reps     (reps),
        .ready    (ready),
        .busy     (busy),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after the accepting edge.
    task automatic start_xfer(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        data  = d;
        len   = l;
        reps  = r;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({ready, busy, bit_valid, bit_out, done} !== 5'b10000)
            $display("FAIL reset_outputs: got %b want 10000",
                     {ready, busy, bit_valid, bit_out, done});
        else passed++;
        rst = 1'b0;
        step();
        total++;
        if ({ready, bit_valid, done} !== 3'b100)
            $display("FAIL reset_idle: got %b want 100", {ready, bit_valid, done});
        else passed++;
    endtask

    task automatic test_single();
        logic [7:0] exp = 8'b1011_0111;
        start_xfer(8'b1011_0111, 4'd8, 4'd1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({bit_valid, bit_out, busy, ready} !== {1'b1, exp[7-i], 1'b1, 1'b0})
                $display("FAIL single_bit%0d: got v/b/busy/rdy=%b want %b", i,
                         {bit_valid, bit_out, busy, ready}, {1'b1, exp[7-i], 1'b1, 1'b0});
            else passed++;
            step();
        end
        total++;
        if ({done, bit_valid, bit_out, ready, busy} !== 5'b10000)
            $display("FAIL single_done: got %b want 10000",
                     {done, bit_valid, bit_out, ready, busy});
        else passed++;
        step();
        total++;
        if ({ready, done} !== 2'b10)
            $display("FAIL single_ready: got %b want 10", {ready, done});
        else passed++;
    endtask

    task automatic test_reps();
        logic [10:0] exp = 11'b111_0_111_0_111;
        int run = 0;
        int dets = 0;
        start_xfer(8'h07, 4'd3, 4'd3);
        for (int i = 0; i < 11; i++) begin
            total++;
            if ({bit_valid, bit_out} !== {exp[10-i], exp[10-i]})
                $display("FAIL reps_cycle%0d: got v/b=%b want %b", i,
                         {bit_valid, bit_out}, {exp[10-i], exp[10-i]});
            else passed++;
            // Reference "111" detector: fires on entry to a run of three valid ones.
            if (bit_valid && bit_out) begin
                run++;
                if (run == 3) dets++;
            end else begin
                run = 0;
            end
            step();
        end
        total++;
        if ({done, bit_valid} !== 2'b10)
            $display("FAIL reps_done: got %b want 10", {done, bit_valid});
        else passed++;
        total++;
        if (dets !== 3) $display("FAIL reps_detect: got %0d want 3", dets);
        else passed++;
        step();
    endtask

    task automatic test_len0();
        start_xfer(8'hFF, 4'd0, 4'd5);
        total++;
        if ({done, bit_valid, bit_out, ready} !== 4'b1000)
            $display("FAIL len0_done: got %b want 1000", {done, bit_valid, bit_out, ready});
        else passed++;
        step();
        total++;
        if ({ready, done, bit_valid} !== 3'b100)
            $display("FAIL len0_idle: got %b want 100", {ready, done, bit_valid});
        else passed++;
    endtask

    task automatic test_clamp();
        logic [7:0] exp = 8'b1010_0101;
        start_xfer(8'hA5, 4'd12, 4'd1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({bit_valid, bit_out} !== {1'b1, exp[7-i]})
                $display("FAIL clamp_bit%0d: got %b want %b", i, {bit_valid, bit_out},
                         {1'b1, exp[7-i]});
            else passed++;
            step();
        end
        total++;
        if ({done, bit_valid} !== 2'b10)
            $display("FAIL clamp_done: got %b want 10", {done, bit_valid});
        else passed++;
        step();
    endtask

    task automatic test_ignore();
        logic [7:0] exp = 8'b1100_0011;
        start_xfer(8'hC3, 4'd8, 4'd1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({bit_valid, bit_out} !== {1'b1, exp[7-i]})
                $display("FAIL ignore_bit%0d: got %b want %b", i, {bit_valid, bit_out},
                         {1'b1, exp[7-i]});
            else passed++;
            if (i == 2) begin
                data  = 8'h3C;
                len   = 4'd2;
                reps  = 4'd4;
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            step();
        end
        total++;
        if ({done, bit_valid} !== 2'b10)
            $display("FAIL ignore_done: got %b want 10", {done, bit_valid});
        else passed++;
        step();
        total++;
        if ({ready, bit_valid} !== 2'b10)
            $display("FAIL ignore_idle: got %b want 10", {ready, bit_valid});
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp = 8'b1000_0001;
        logic       seen_done = 1'b0;
        start_xfer(8'hFF, 4'd8, 4'd1);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        total++;
        if ({bit_out, bit_valid, ready, done, busy} !== 5'b00100)
            $display("FAIL rstmid_cut: got %b want 00100",
                     {bit_out, bit_valid, ready, done, busy});
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done || bit_valid) seen_done = 1'b1;
            step();
        end
        total++;
        if (seen_done !== 1'b0) $display("FAIL rstmid_quiet: got %b want 0", seen_done);
        else passed++;
        start_xfer(8'h81, 4'd8, 4'd1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({bit_valid, bit_out} !== {1'b1, exp[7-i]})
                $display("FAIL rstmid_bit%0d: got %b want %b", i, {bit_valid, bit_out},
                         {1'b1, exp[7-i]});
            else passed++;
            step();
        end
        total++;
        if (done !== 1'b1) $display("FAIL rstmid_done: got %b want 1", done);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        data  = 8'h05;
        len   = 4'd2;
        reps  = 4'd1;
        start = 1'b1;
        step();
        // cycles: 1,2 bits 0,1; 3 done; 4 idle (re-accept); 5,6 bits again
        total++;
        if ({bit_valid, bit_out} !== 2'b10)
            $display("FAIL b2b_bit0: got %b want 10", {bit_valid, bit_out});
        else passed++;
        step();
        total++;
        if ({bit_valid, bit_out} !== 2'b11)
            $display("FAIL b2b_bit1: got %b want 11", {bit_valid, bit_out});
        else passed++;
        step();
        total++;
        if ({done, ready} !== 2'b10)
            $display("FAIL b2b_done: got %b want 10", {done, ready});
        else passed++;
        step();
        total++;
        if ({ready, done, bit_valid} !== 3'b100)
            $display("FAIL b2b_idle: got %b want 100", {ready, done, bit_valid});
        else passed++;
        step();
        start = 1'b0;
        total++;
        if ({bit_valid, bit_out, ready} !== 3'b100)
            $display("FAIL b2b_second: got %b want 100", {bit_valid, bit_out, ready});
        else passed++;
        step();
        step();
        total++;
        if (done !== 1'b1) $display("FAIL b2b_done2: got %b want 1", done);
        else passed++;
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_reps();
        test_len0();
        test_clamp();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
